// File: rtl/mix_columns_iter.sv
// AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Inverse mode is built only when MIXCOL_INV_EN is defined.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NCYC = 4 / COLS_PER_CYCLE;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [127:0]  work;
    logic [127:0]  work_nxt;
    logic [127:0]  mixed;
    logic [1:0]    idx;
    logic          accept;
    logic          last;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        for (int r = 0; r < 4; r++)
            b[r] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                 ^ a[(r+2)%4] ^ a[(r+3)%4];
        return {b[0], b[1], b[2], b[3]};
    endfunction

`ifdef MIXCOL_INV_EN
    logic inv_q;

    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] b  [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int r = 0; r < 4; r++)
            b[r] = x8[r] ^ x4[r] ^ x2[r]
                 ^ x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4]
                 ^ x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4]
                 ^ x8[(r+3)%4] ^ a[(r+3)%4];
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // direction bit captured with the state it applies to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv_q <= 1'b0;
        else if (accept) inv_q <= in_inv;
    end
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    assign accept    = in_valid & in_ready;
    assign last      = (cnt == CW'(NCYC - 1));
    assign in_ready  = rst_n & ((state == IDLE) |
                                ((state == DONE) & out_ready));
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign out_data  = work;

    // transform the column slice selected by the counter, rest passes through
    always_comb begin
        mixed = work;
        idx   = 2'd0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            idx = 2'(int'(cnt) * COLS_PER_CYCLE + k);
`ifdef MIXCOL_INV_EN
            mixed[{~idx, 5'b0} +: 32] = inv_q ?
                inv_col(work[{~idx, 5'b0} +: 32]) :
                fwd_col(work[{~idx, 5'b0} +: 32]);
`else
            mixed[{~idx, 5'b0} +: 32] = fwd_col(work[{~idx, 5'b0} +: 32]);
`endif
        end
    end

    // next-state, counter and working-register update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        work_nxt  = work;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    work_nxt  = in_data;
                end
            end
            BUSY: begin
                work_nxt = mixed;
                if (last) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_nxt = BUSY;
                        work_nxt  = in_data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, column counter and working register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            work  <= work_nxt;
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: directed FIPS-197 vectors plus random traffic
// checked against a GF(2^8) matrix-product model.
module tb_mix_columns_iter;

    parameter int COLS = 1;
    localparam int NCYC = 4 / COLS;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] D4_IN    = 128'hd4bf5d30_d4bf5d30_d4bf5d30_d4bf5d30;
    localparam logic [127:0] D4_OUT   = 128'h046681e5_046681e5_046681e5_046681e5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    mix_columns_iter #(.COLS_PER_CYCLE(COLS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // carry-less product then reduction by 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s,
                                           input logic inv);
        logic [7:0]   co [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) begin
            co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09;
        end else begin
            co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01;
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(co[k], s[127-32*c-8*((r+k)%4) -: 8]);
                o[127-32*c-8*r -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] expect_of(input logic [127:0] s,
                                               input logic inv);
`ifdef MIXCOL_INV_EN
        return model(s, inv);
`else
        if (inv) return model(s, 1'b0);
        return model(s, 1'b0);
`endif
    endfunction

    // scoreboard: record accepted states, check every delivered/held output
    logic [127:0] exp_q [$];
    logic [127:0] held;
    logic         holding = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            holding = 1'b0;
        end else begin
            if (holding) begin
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_data", out_data, held);
            end
            holding = out_valid & ~out_ready;
            held    = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none",
                             out_data);
                end else begin
                    chk("data", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(expect_of(in_data, in_inv));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_wait(input logic [127:0] d, input logic inv,
                             output int lat, output logic [127:0] res);
        int n;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk_i("accept_timeout", n, 0);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        res = out_data;
    endtask

    int           lat;
    logic [127:0] res;
    int           sent;
    int           cyc;
    logic         acc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));

        chk("model_fwd", model(FIPS_IN, 1'b0), FIPS_OUT);
        chk("model_inv", model(FIPS_OUT, 1'b1), FIPS_IN);
        chk("model_d4", model(D4_IN, 1'b0), D4_OUT);

        repeat (2) step();
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 128'(in_ready), 128'(1));

        out_ready = 1'b1;
        send_wait(FIPS_IN, 1'b0, lat, res);
        chk_i("fips_latency", lat, NCYC);
        chk("fips_data", res, FIPS_OUT);
        step();
        chk("taken_out_valid", 128'(out_valid), 128'(0));

        send_wait(FIPS_OUT, 1'b1, lat, res);
`ifdef MIXCOL_INV_EN
        chk("inv_data", res, FIPS_IN);
`else
        chk("inv_ignored", res, model(FIPS_OUT, 1'b0));
`endif
        step();

        send_wait(D4_IN, 1'b0, lat, res);
        chk_i("d4_latency", lat, NCYC);
        chk("d4_data", res, D4_OUT);
        step();

        out_ready = 1'b0;
        send_wait(FIPS_IN, 1'b0, lat, res);
        repeat (10) step();
        chk("bp_data", out_data, FIPS_OUT);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_out_valid", 128'(out_valid), 128'(1));
        in_data   = D4_IN;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        chk("b2b_busy", 128'(busy), 128'(1));
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        chk("b2b_data", out_data, D4_OUT);
        step();

        in_data  = FIPS_IN;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (NCYC == 4) repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_data", out_data, 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        repeat (2) step();
        rst_n = 1'b1;
        send_wait(FIPS_IN, 1'b0, lat, res);
        chk_i("post_rst_latency", lat, NCYC);
        chk("post_rst_data", res, FIPS_OUT);
        step();

        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                in_inv   = 1'($urandom_range(0, 1));
            end
            #1;
            acc = in_valid & in_ready;
            step();
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk_i("random_sent", sent, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        chk_i("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
